// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: drives the core reset window, the shared trig/check strobes and stall monitoring
module rvfi_check_sequencer #(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_CYCLE   = 10,
    parameter int CHECK_CYCLE  = 20,
    parameter int HANG_LIMIT   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NRET-1:0] rvfi_valid,
    output logic            core_reset,
    output logic            trig,
    output logic            check,
    output logic            done,
    output logic            pass,
    output logic            hang,
    output logic [15:0]     retire_count,
    output logic [7:0]      idle_count
);
    if (NRET < 1 || NRET > 8 || RESET_CYCLES < 1 || RESET_CYCLES > 255 ||
        TRIG_CYCLE < 0 || TRIG_CYCLE >= CHECK_CYCLE || CHECK_CYCLE > 65535 ||
        HANG_LIMIT < 1 || HANG_LIMIT > 255) begin : g_bad_params
        $error("rvfi_check_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [7:0]  LP_HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [15:0] LP_TRIG      = 16'(TRIG_CYCLE);
    localparam logic [15:0] LP_CHECK     = 16'(CHECK_CYCLE);
    localparam logic [7:0]  LP_HANG      = 8'(HANG_LIMIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cyc;
    logic [7:0]  r_hold_cnt;
    logic        r_seen;
    logic        r_core_reset;
    logic        r_done;
    logic        r_pass;
    logic        r_hang;
    logic [15:0] r_retire_count;
    logic [7:0]  r_idle_count;
    logic        w_any;
    logic        w_hold_end;
    logic        w_check_end;
    logic        w_track;
    logic        w_in_window;
    logic [3:0]  w_pop;
    logic [16:0] w_retire_sum;
    logic [7:0]  w_idle_next;

    // Retirement popcount across every channel
    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < NRET; i++) w_pop = w_pop + {3'b0, rvfi_valid[i]};
    end

    // Phase decodes and saturating counter next values
    always_comb begin
        w_any        = |rvfi_valid;
        w_hold_end   = (r_state == HOLD) && (r_hold_cnt == LP_HOLD_LAST);
        w_check_end  = (r_state == RUN) && (r_cyc == LP_CHECK);
        w_track      = (r_state == RUN) || (r_state == DONE);
        w_in_window  = (r_cyc >= LP_TRIG) && (r_cyc <= LP_CHECK);
        w_retire_sum = {1'b0, r_retire_count} + {13'b0, w_pop};
        w_idle_next  = w_any ? 8'd0 : (r_idle_count == LP_HANG) ? LP_HANG : r_idle_count + 8'd1;
        w_state_next = w_hold_end ? RUN : w_check_end ? DONE : r_state;
    end

    // Sequence state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= HOLD;
        else r_state <= w_state_next;
    end

    // Reset window, cycle counter and pass/done capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_cnt   <= 8'd0;
            r_cyc        <= 16'd0;
            r_seen       <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            if (r_state == HOLD) r_hold_cnt <= r_hold_cnt + 8'd1;
            if (w_hold_end) begin
                r_core_reset <= 1'b0;
                r_cyc        <= 16'd0;
            end else if (r_state == RUN) begin
                r_cyc <= r_cyc + 16'd1;
            end
            if (r_state == RUN && w_in_window && w_any) r_seen <= 1'b1;
            if (w_check_end) begin
                r_done <= 1'b1;
                r_pass <= r_seen | w_any;
            end
        end
    end

    // Retirement and stall tracking once the core is out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_count <= 16'd0;
            r_idle_count   <= 8'd0;
            r_hang         <= 1'b0;
        end else if (w_track) begin
            r_retire_count <= w_retire_sum[16] ? 16'hFFFF : w_retire_sum[15:0];
            r_idle_count   <= w_idle_next;
            if (w_idle_next == LP_HANG) r_hang <= 1'b1;
        end
    end

    assign core_reset   = r_core_reset;
    assign trig         = (r_state == RUN) && (r_cyc == LP_TRIG);
    assign check        = (r_state == RUN) && (r_cyc == LP_CHECK);
    assign done         = r_done;
    assign pass         = r_pass;
    assign hang         = r_hang;
    assign retire_count = r_retire_count;
    assign idle_count   = r_idle_count;
endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb_rvfi_check_sequencer: randomized and directed checks of two sequencer configurations against a cycle-count model
module tb_rvfi_check_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic        cr [2];
    logic        tg [2];
    logic        ck [2];
    logic        dn [2];
    logic        ps [2];
    logic        hg [2];
    logic [15:0] rc [2];
    logic [7:0]  ic [2];

    int checks = 0;
    int errors = 0;
    int scen   = 0;

    // model: m_n = edges since reset released; cycle n is RUN index n-RESET_CYCLES
    int m_n    [2];
    int m_ret  [2];
    int m_idle [2];
    bit m_hang [2];
    bit m_seen [2];
    bit m_pass [2];

    int trig_pre;
    int trig_post;

    rvfi_check_sequencer u0 (
        .clock(clock), .reset(reset), .rvfi_valid(valid[0]),
        .core_reset(cr[0]), .trig(tg[0]), .check(ck[0]), .done(dn[0]), .pass(ps[0]),
        .hang(hg[0]), .retire_count(rc[0]), .idle_count(ic[0])
    );

    rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(4)) u1 (
        .clock(clock), .reset(reset), .rvfi_valid(valid),
        .core_reset(cr[1]), .trig(tg[1]), .check(ck[1]), .done(dn[1]), .pass(ps[1]),
        .hang(hg[1]), .retire_count(rc[1]), .idle_count(ic[1])
    );

    function automatic int rcy(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int pop(input int k);
        return (k == 0) ? int'(valid[0]) : int'(valid[0]) + int'(valid[1]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (scenario %0d): got %0d expected %0d", name, scen, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_n[k] = 0; m_ret[k] = 0; m_idle[k] = 0;
                m_hang[k] = 0; m_seen[k] = 0; m_pass[k] = 0;
            end else begin
                if (m_n[k] >= rcy(k)) begin
                    int c;
                    int p;
                    c = m_n[k] - rcy(k);
                    p = pop(k);
                    m_ret[k]  = (m_ret[k] + p > 65535) ? 65535 : m_ret[k] + p;
                    m_idle[k] = (p != 0) ? 0 : (m_idle[k] + 1 > 16) ? 16 : m_idle[k] + 1;
                    if (m_idle[k] == 16) m_hang[k] = 1;
                    if (p != 0 && c >= 10 && c <= 20) m_seen[k] = 1;
                    if (c == 20) m_pass[k] = m_seen[k];
                end
                if (m_n[k] < 1000000) m_n[k]++;
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            int c;
            bit run;
            c = m_n[k] - rcy(k);
            run = m_n[k] >= rcy(k);
            chk($sformatf("core_reset%0d", k), int'(cr[k]), int'(!run));
            chk($sformatf("trig%0d", k), int'(tg[k]), int'(run && c == 10));
            chk($sformatf("check%0d", k), int'(ck[k]), int'(run && c == 20));
            chk($sformatf("done%0d", k), int'(dn[k]), int'(run && c > 20));
            chk($sformatf("pass%0d", k), int'(ps[k]), int'(m_pass[k]));
            chk($sformatf("hang%0d", k), int'(hg[k]), int'(m_hang[k]));
            chk($sformatf("retire_count%0d", k), int'(rc[k]), m_ret[k]);
            chk($sformatf("idle_count%0d", k), int'(ic[k]), m_idle[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic pins(input int s);
        if (s == 0 && m_n[0] == 22) begin
            chk("pin_ones_retire0", int'(rc[0]), 21);
            chk("pin_ones_done0", int'(dn[0]), 1);
            chk("pin_ones_pass0", int'(ps[0]), 1);
            chk("pin_ones_hang0", int'(hg[0]), 0);
        end
        if (s == 0 && m_n[1] == 3) chk("pin_hold_cr1", int'(cr[1]), 1);
        if (s == 0 && m_n[1] == 4) begin
            chk("pin_hold_cr1_fall", int'(cr[1]), 0);
            chk("pin_hold_retire1", int'(rc[1]), 0);
        end
        if (s == 0 && m_n[1] == 5) chk("pin_first_retire1", int'(rc[1]), 2);
        if (s == 1 && m_n[0] == 16) begin
            chk("pin_idle15", int'(ic[0]), 15);
            chk("pin_nohang", int'(hg[0]), 0);
        end
        if (s == 1 && m_n[0] == 17) begin
            chk("pin_idle16", int'(ic[0]), 16);
            chk("pin_hang", int'(hg[0]), 1);
        end
        if (s == 1 && m_n[0] == 40) begin
            chk("pin_zero_pass0", int'(ps[0]), 0);
            chk("pin_idle_hold", int'(ic[0]), 16);
        end
        if (s == 2 && m_n[1] == 25) begin
            chk("pin_late_pass1", int'(ps[1]), 1);
            chk("pin_late_retire1", int'(rc[1]), 2);
            chk("pin_late_hang1", int'(hg[1]), 1);
        end
        if (s == 3 && m_n[0] == 11) begin
            chk("pin_c9_idle0", int'(ic[0]), 0);
            chk("pin_c9_retire0", int'(rc[0]), 1);
        end
        if (s == 3 && m_n[0] == 22) chk("pin_c9_pass0", int'(ps[0]), 0);
    endtask

    task automatic scenario(input int s, input int len);
        bit aborted;
        aborted = 0;
        scen = s;
        trig_pre = 0;
        trig_post = 0;
        reset = 1'b1;
        valid = 2'b00;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < len; i++) begin
            int c0;
            int c1;
            logic [1:0] v;
            bit rs;
            c0 = m_n[0] - rcy(0);
            c1 = m_n[1] - rcy(1);
            rs = 0;
            case (s)
                0: v = 2'b11;
                1: v = 2'b00;
                2: v = (c1 == 20) ? 2'b11 : 2'b00;
                3: v = {c1 == 9, c0 == 9};
                4: v = 2'($urandom_range(0, 3));
                6: v = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                default: begin
                    v = 2'($urandom_range(0, 3));
                    rs = !aborted && c0 == 12;
                end
            endcase
            valid = v;
            reset = rs;
            cycle();
            reset = 1'b0;
            if (rs) begin
                aborted = 1;
                chk("pin_abort_cr0", int'(cr[0]), 1);
                chk("pin_abort_done0", int'(dn[0]), 0);
                chk("pin_abort_retire0", int'(rc[0]), 0);
            end
            if (s == 5 && tg[0] === 1'b1) begin
                if (aborted) trig_post++;
                else trig_pre++;
            end
            pins(s);
        end
        if (s == 5) begin
            chk("pin_trig_before_abort", trig_pre, 1);
            chk("pin_trig_after_abort", trig_post, 1);
        end
    endtask

    initial begin
        @(negedge clock);
        scenario(0, 40);
        scenario(1, 40);
        scenario(2, 40);
        scenario(3, 40);
        scenario(4, 120);
        scenario(6, 200);
        scenario(5, 60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
